// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the load/store initiator.
package mem_access_unit_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4,
        ERR  = 3'd5
    } state_t;

    // Request fields held for the lifetime of one access
    typedef struct packed {
        logic              write;
        logic [1:0]        size;
        logic              uns;
        logic [1:0]        offset;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // Full-word stores skip the read half of read-modify-write
    function automatic logic is_word_store(input logic write, input logic [1:0] size);
        return write && (size == SZ_WORD);
    endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane_align.sv
// Little-endian lane extraction/extension for loads, lane merge for stores,
// and alignment checking. Purely combinational.
module byte_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]        i_size,
    input  logic [1:0]        i_offset,
    input  logic              i_unsigned,
    input  logic [DATA_W-1:0] i_mem_word,
    input  logic [DATA_W-1:0] i_store_data,
    output logic [DATA_W-1:0] o_load_data_c,
    output logic [DATA_W-1:0] o_merged_word_c,
    output logic              o_misaligned_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte          = i_mem_word[{i_offset, 3'b000} +: 8];
        w_half          = i_mem_word[{i_offset[1], 4'b0000} +: 16];
        o_load_data_c   = i_mem_word;
        o_merged_word_c = i_mem_word;
        case (i_size)
            SZ_BYTE: begin
                o_load_data_c = i_unsigned ? {24'h000000, w_byte}
                                           : {{24{w_byte[7]}}, w_byte};
                o_merged_word_c[{i_offset, 3'b000} +: 8] = i_store_data[7:0];
            end
            SZ_HALF: begin
                o_load_data_c = i_unsigned ? {16'h0000, w_half}
                                           : {{16{w_half[15]}}, w_half};
                o_merged_word_c[{i_offset[1], 4'b0000} +: 16] = i_store_data[15:0];
            end
            default: begin
                o_load_data_c   = i_mem_word;
                o_merged_word_c = i_store_data;
            end
        endcase
    end

    assign o_misaligned_c = (i_size == 2'b11)
                          || ((i_size == SZ_HALF) && i_offset[0])
                          || ((i_size == SZ_WORD) && (i_offset != 2'b00));

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: one byte/half/word access at a time against a
// word-addressed memory with a registered read port.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_misaligned,
    output logic              stall,
    output logic              mem_lMem,
    output logic              mem_escMem,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t              r_state;
    req_t                r_req;
    logic                r_ready;
    logic                r_stall;
    logic                r_rsp_valid;
    logic                r_rsp_mis;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_lmem;
    logic                r_escmem;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic                w_idle;
    logic [1:0]          w_size;
    logic [1:0]          w_offset;
    logic                w_uns;
    logic [DATA_W-1:0]   w_load_data;
    logic [DATA_W-1:0]   w_merged_word;
    logic                w_misaligned;
    logic                w_unused_addr;

    // Upper address bits wrap modulo the memory size
    assign w_unused_addr = ^req_addr[DATA_W-1:ADDR_W+2];

    // The aligner checks the incoming request while idle, the held one otherwise
    assign w_idle   = (r_state == IDLE);
    assign w_size   = w_idle ? req_size     : r_req.size;
    assign w_offset = w_idle ? req_addr[1:0] : r_req.offset;
    assign w_uns    = w_idle ? req_unsigned : r_req.uns;

    byte_lane_align u_align (
        .i_size          (w_size),
        .i_offset        (w_offset),
        .i_unsigned      (w_uns),
        .i_mem_word      (mem_rdata),
        .i_store_data    (r_req.wdata),
        .o_load_data_c   (w_load_data),
        .o_merged_word_c (w_merged_word),
        .o_misaligned_c  (w_misaligned)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_req       <= '0;
            r_ready     <= 1'b1;
            r_stall     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_mis   <= 1'b0;
            r_rsp_rdata <= '0;
            r_lmem      <= 1'b0;
            r_escmem    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_mis   <= 1'b0;
            r_lmem      <= 1'b0;
            r_escmem    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_req   <= '{write:  req_write,
                                     size:   req_size,
                                     uns:    req_unsigned,
                                     offset: req_addr[1:0],
                                     wdata:  req_wdata};
                        r_ready <= 1'b0;
                        r_stall <= 1'b1;
                        if (w_misaligned) begin
                            r_state     <= ERR;
                            r_rsp_valid <= 1'b1;
                            r_rsp_mis   <= 1'b1;
                        end else begin
                            r_mem_addr <= req_addr[ADDR_W+1:2];
                            if (is_word_store(req_write, req_size)) begin
                                r_state     <= WR;
                                r_escmem    <= 1'b1;
                                r_mem_wdata <= req_wdata;
                            end else begin
                                r_state <= RD;
                                r_lmem  <= 1'b1;
                            end
                        end
                    end
                end
                RD: r_state <= CAP;
                CAP: begin
                    if (r_req.write) begin
                        r_state     <= WR;
                        r_escmem    <= 1'b1;
                        r_mem_wdata <= w_merged_word;
                    end else begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_load_data;
                    end
                end
                WR: begin
                    r_state     <= RESP;
                    r_rsp_valid <= 1'b1;
                end
                RESP, ERR: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_stall <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready      = r_ready;
    assign stall          = r_stall;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_misaligned = r_rsp_mis;
    assign rsp_rdata      = r_rsp_rdata;
    assign mem_lMem       = r_lmem;
    assign mem_escMem     = r_escmem;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level model predicts
// latency, strobes, memory contents and load data; every access also carries
// a hand-computed literal.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic        stall;
    logic        mem_lMem;
    logic        mem_escMem;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] lit_val = 32'h0;

    always #5 clock = ~clock;

    mem_access_unit #(.ADDR_W(5)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_misaligned (rsp_misaligned),
        .stall          (stall),
        .mem_lMem       (mem_lMem),
        .mem_escMem     (mem_escMem),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    // Data memory as seen by the DUT: registered read, synchronous write
    logic [31:0] phys [32];
    always @(posedge clock) begin
        if (mem_lMem)   mem_rdata <= phys[mem_addr];
        if (mem_escMem) phys[mem_addr] <= mem_wdata;
    end

    function automatic logic f_bad(input logic [1:0] sz, input int off);
        return (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
    endfunction

    function automatic logic [4:0] f_idx(input logic [31:0] a);
        return 5'((a >> 2) % 32);
    endfunction

    function automatic logic [31:0] f_load(input logic [31:0] w, input int off,
                                           input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        v = w >> (8 * off);
        if (sz == 2'd0) begin
            v = v & 32'hFF;
            if (!uns && v >= 32'd128) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] w, input int off,
                                            input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] mask;
        if (sz == 2'd2) return d;
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
        return (w & ~mask) | ((d << (8 * off)) & mask);
    endfunction

    // Transaction-level reference: one outstanding access, fixed latency per kind
    logic [31:0] ref_mem [32];
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    int          m_lat = 0;
    int          m_acc = 0;
    logic [4:0]  m_idx = 5'd0;
    logic        m_mis = 1'b0;
    logic        m_write = 1'b0;
    logic        m_elm = 1'b0;
    logic        m_ees = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic [31:0] m_new_word = 32'h0;
    logic [31:0] m_lit = 32'h0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy  <= 1'b0;
            m_cnt   <= 0;
            m_rdata <= 32'h0;
        end else if (m_busy) begin
            if (m_cnt == m_lat) begin
                m_busy <= 1'b0;
                if (m_write && !m_mis) ref_mem[m_idx] <= m_new_word;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (req_valid) begin
            m_busy     <= 1'b1;
            m_cnt      <= 1;
            m_acc      <= m_acc + 1;
            m_idx      <= f_idx(req_addr);
            m_write    <= req_write;
            m_lit      <= lit_val;
            m_mis      <= f_bad(req_size, int'(req_addr[1:0]));
            m_elm      <= !f_bad(req_size, int'(req_addr[1:0])) && !(req_write && req_size == 2'd2);
            m_ees      <= !f_bad(req_size, int'(req_addr[1:0])) && req_write;
            m_new_word <= f_merge(ref_mem[f_idx(req_addr)], int'(req_addr[1:0]), req_size, req_wdata);
            if (f_bad(req_size, int'(req_addr[1:0])))
                m_lat <= 1;
            else if (req_write)
                m_lat <= (req_size == 2'd2) ? 2 : 4;
            else
                m_lat <= 3;
            if (!f_bad(req_size, int'(req_addr[1:0])) && !req_write)
                m_rdata <= f_load(ref_mem[f_idx(req_addr)], int'(req_addr[1:0]), req_size, req_unsigned);
        end
    end

    int n_checks = 0;
    int n_fail = 0;
    int n_lm = 0;
    int n_es = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Single compare process, sampled on the falling edge
    always @(negedge clock) begin
        if (!reset_n) begin
            chk("rst_ready", 32'(req_ready), 32'd1);
            chk("rst_stall", 32'(stall), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_mis", 32'(rsp_misaligned), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'h0);
            chk("rst_lmem", 32'(mem_lMem), 32'd0);
            chk("rst_escmem", 32'(mem_escMem), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'h0);
            n_lm = 0;
            n_es = 0;
        end else begin
            if (mem_lMem) begin
                n_lm++;
                chk("lmem_addr", 32'(mem_addr), 32'(m_idx));
            end
            if (mem_escMem) begin
                n_es++;
                chk("esc_addr", 32'(mem_addr), 32'(m_idx));
                chk("esc_wdata", mem_wdata, m_new_word);
            end
            chk("strobe_excl", 32'(mem_lMem && mem_escMem), 32'd0);
            chk("ready", 32'(req_ready), 32'(!m_busy));
            chk("stall", 32'(stall), 32'(m_busy));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_cnt == m_lat));
            if (m_busy && m_cnt == m_lat) begin
                chk("rsp_mis", 32'(rsp_misaligned), 32'(m_mis));
                chk("lmem_pulses", 32'(n_lm), 32'(m_elm));
                chk("esc_pulses", 32'(n_es), 32'(m_ees));
                if (m_write && !m_mis) begin
                    chk("mem_word", phys[m_idx], m_new_word);
                    chk("lit_model_word", m_new_word, m_lit);
                    chk("lit_mem_word", phys[m_idx], m_lit);
                end else begin
                    chk("rsp_rdata", rsp_rdata, m_rdata);
                    chk("lit_model_rdata", m_rdata, m_lit);
                    chk("lit_rsp_rdata", rsp_rdata, m_lit);
                end
                n_lm = 0;
                n_es = 0;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_busy && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (m_busy) begin
            $display("FAIL wait_idle timeout t=%0t", $time);
            $fatal(1, "bench stuck");
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] lv);
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        lit_val      = lv;
        req_valid    = 1'b1;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] lv);
        @(negedge clock);
        wait_idle();
        drive(w, sz, u, a, d, lv);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        int start_acc;
        int n;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;

        // word store / load
        issue(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 32'hDEADBEEF);

        // byte and half loads with extension
        issue(1'b1, 2'd2, 1'b0, 32'h04, 32'h80FF7F01, 32'h80FF7F01);
        issue(1'b0, 2'd0, 1'b0, 32'h05, 32'h0, 32'h0000007F);
        issue(1'b0, 2'd0, 1'b0, 32'h07, 32'h0, 32'hFFFFFF80);
        issue(1'b0, 2'd0, 1'b1, 32'h07, 32'h0, 32'h00000080);
        issue(1'b0, 2'd1, 1'b0, 32'h06, 32'h0, 32'hFFFF80FF);
        issue(1'b0, 2'd1, 1'b1, 32'h04, 32'h0, 32'h00007F01);
        issue(1'b0, 2'd1, 1'b0, 32'h04, 32'h0, 32'h00007F01);

        // sub-word read-modify-write
        issue(1'b1, 2'd2, 1'b0, 32'h0C, 32'h11223344, 32'h11223344);
        issue(1'b1, 2'd1, 1'b0, 32'h0E, 32'h0000AAAA, 32'hAAAA3344);
        issue(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 32'hAAAA3344);
        issue(1'b1, 2'd0, 1'b0, 32'h0D, 32'h12345655, 32'hAAAA5544);
        issue(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 32'hAAAA5544);
        issue(1'b0, 2'd1, 1'b1, 32'h0E, 32'h0, 32'h0000AAAA);

        // misaligned: rsp_rdata keeps the last load value
        issue(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 32'h0000AAAA);
        issue(1'b0, 2'd1, 1'b0, 32'h01, 32'h0, 32'h0000AAAA);
        issue(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 32'h0000AAAA);
        issue(1'b1, 2'd2, 1'b0, 32'h09, 32'h55555555, 32'h0000AAAA);
        issue(1'b1, 2'd1, 1'b0, 32'h03, 32'h00007777, 32'h0000AAAA);

        // reset while a half store sits in CAP
        @(negedge clock);
        wait_idle();
        drive(1'b1, 2'd1, 1'b0, 32'h0E, 32'h00007777, 32'h0);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 32'hAAAA5544);

        // address wrap
        issue(1'b1, 2'd2, 1'b0, 32'h80, 32'hCAFEF00D, 32'hCAFEF00D);
        issue(1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 32'hCAFEF00D);
        issue(1'b0, 2'd2, 1'b0, 32'h88, 32'h0, 32'hDEADBEEF);
        issue(1'b0, 2'd0, 1'b0, 32'h00, 32'h0, 32'h0000000D);
        issue(1'b0, 2'd1, 1'b0, 32'h02, 32'h0, 32'hFFFFCAFE);

        // req_valid held through busy: a second capture only once ready returns
        @(negedge clock);
        wait_idle();
        start_acc = m_acc;
        drive(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 32'hDEADBEEF);
        n = 0;
        while (m_acc < start_acc + 2 && n < 30) begin
            @(negedge clock);
            n++;
        end
        req_valid = 1'b0;
        if (m_acc < start_acc + 2) begin
            $display("FAIL hold_valid timeout t=%0t", $time);
            $fatal(1, "bench stuck");
        end
        wait_idle();

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
